// File: rtl/io_cond_pkg.sv
// Shared defaults and reset-sequencer state type for the player-input conditioner.
package io_cond_pkg;

  localparam int IO_COND_NUM_CH          = 4;
  localparam int IO_COND_SYNC_STAGES     = 2;
  localparam int IO_COND_DEBOUNCE_CYCLES = 250000;
  localparam int IO_COND_RESET_HOLD      = 16;

  typedef enum logic {
    RST_HOLD = 1'b0,
    RST_RUN  = 1'b1
  } rst_state_t;

endpackage

// File: rtl/io_debounce_chan.sv
// One button channel: inverting synchroniser, debounce counter and, with
// IO_COND_EDGE_EN defined, registered press/release pulses.
module io_debounce_chan
  import io_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = IO_COND_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = IO_COND_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_n,
  input  logic hold_next,
  output logic level,
  output logic press,
  output logic fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;
  logic                   s;
  logic                   accept;

  assign s      = sync_q[SYNC_STAGES-1];
  assign accept = (s != level_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign level  = level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ~pin_n};
      // Any agreeing cycle restarts the count; acceptance clears it.
      if (s == level_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        level_q <= s;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef IO_COND_EDGE_EN
  logic press_q;
  logic fall_q;

  // Gated with the sequencer's next state so pulses never coincide with design reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      press_q <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      press_q <= accept & s & ~hold_next;
      fall_q  <= accept & ~s & ~hold_next;
    end
  end

  assign press = press_q;
  assign fall  = fall_q;
`else
  logic unused_hold_next;
  assign unused_hold_next = hold_next;
  assign press = 1'b0;
  assign fall  = 1'b0;
`endif

endmodule

// File: rtl/io_input_conditioner.sv
// Player-input front end: per-channel debounce plus a reset sequencer merging
// wb_rst_i, ext_reset_n and gpio_ready. Edge pulses need IO_COND_EDGE_EN.
module io_input_conditioner
  import io_cond_pkg::*;
#(
  parameter int NUM_CH          = IO_COND_NUM_CH,
  parameter int SYNC_STAGES     = IO_COND_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = IO_COND_DEBOUNCE_CYCLES,
  parameter int RESET_HOLD      = IO_COND_RESET_HOLD
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              ext_reset_n,
  input  logic              gpio_ready,
  input  logic [NUM_CH-1:0] btn_n_i,
  output logic [NUM_CH-1:0] btn_o,
  output logic [NUM_CH-1:0] btn_press_o,
  output logic [NUM_CH-1:0] btn_release_o,
  output logic              design_reset_o,
  output logic              debug_gpio_ready_o
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  logic [SYNC_STAGES-1:0] ext_sync_q;
  rst_state_t             state_q;
  rst_state_t             state_d;
  logic [HOLD_W-1:0]      hold_cnt_q;
  logic [HOLD_W-1:0]      hold_cnt_d;
  logic                   cause;
  logic                   hold_next;
  logic                   dbg_q;

  // External reset is synchronised as a level; flops reset to "asserted".
  assign cause     = wb_rst_i | ~ext_sync_q[SYNC_STAGES-1] | ~gpio_ready;
  assign hold_next = (state_d == RST_HOLD);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    if (cause) begin
      state_d    = RST_HOLD;
      hold_cnt_d = '0;
    end else if (state_q == RST_HOLD) begin
      if (hold_cnt_q == HOLD_W'(RESET_HOLD - 1)) begin
        state_d    = RST_RUN;
        hold_cnt_d = '0;
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ext_sync_q <= '0;
      state_q    <= RST_HOLD;
      hold_cnt_q <= '0;
      dbg_q      <= 1'b0;
    end else begin
      ext_sync_q <= {ext_sync_q[SYNC_STAGES-2:0], ext_reset_n};
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      dbg_q      <= gpio_ready;
    end
  end

  assign design_reset_o     = (state_q == RST_HOLD);
  assign debug_gpio_ready_o = dbg_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    io_debounce_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk      (wb_clk_i),
      .rst      (wb_rst_i),
      .pin_n    (btn_n_i[i]),
      .hold_next(hold_next),
      .level    (btn_o[i]),
      .press    (btn_press_o[i]),
      .fall     (btn_release_o[i])
    );
  end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner: directed scenarios with literal expectations,
// then random pins, all checked every cycle against a window-based model.
module tb_io_input_conditioner;

  localparam int NCH  = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 8;
  localparam int RH   = 4;
  localparam int MAXC = 2048;
`ifdef IO_COND_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic           clk;
  logic           wb_rst_i;
  logic           ext_reset_n;
  logic           gpio_ready;
  logic [NCH-1:0] btn_n_i;
  logic [NCH-1:0] btn_o;
  logic [NCH-1:0] btn_press_o;
  logic [NCH-1:0] btn_release_o;
  logic           design_reset_o;
  logic           debug_gpio_ready_o;

  io_input_conditioner #(
    .NUM_CH(NCH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .RESET_HOLD(RH)
  ) dut (
    .wb_clk_i          (clk),
    .wb_rst_i          (wb_rst_i),
    .ext_reset_n       (ext_reset_n),
    .gpio_ready        (gpio_ready),
    .btn_n_i           (btn_n_i),
    .btn_o             (btn_o),
    .btn_press_o       (btn_press_o),
    .btn_release_o     (btn_release_o),
    .design_reset_o    (design_reset_o),
    .debug_gpio_ready_o(debug_gpio_ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int cyc, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
  endtask

  // Input history and derived cause history, indexed by cycle.
  bit           rst_h   [MAXC];
  bit           ext_h   [MAXC];
  bit           cause_h [MAXC];
  bit [NCH-1:0] pin_h   [MAXC];

  function automatic bit rst_at(int k);
    return (k < 0) ? 1'b1 : rst_h[k];
  endfunction

  function automatic bit cause_at(int k);
    return (k < 0) ? 1'b1 : cause_h[k];
  endfunction

  // A synchronised pin reads as its reset value if wb_rst_i was high in any of
  // the last SYNC cycles; otherwise it is the pin as it stood SYNC cycles ago.
  function automatic bit sync_cleared(int c);
    bit r = 1'b0;
    for (int k = 1; k <= SYNC; k++) r |= rst_at(c - k);
    return r;
  endfunction

  // Expected outputs for the current cycle.
  logic [NCH-1:0] exp_btn   = '0;
  logic [NCH-1:0] exp_press = '0;
  logic [NCH-1:0] exp_rel   = '0;
  logic           exp_drst  = 1'b1;
  logic           exp_dbg   = 1'b0;
  int             disagree [NCH];
  int             cyc = 0;

  initial for (int i = 0; i < NCH; i++) disagree[i] = 0;

  always @(negedge clk) begin : model
    bit             clr;
    bit             ext_s;
    bit             s;
    bit             nd;
    logic [NCH-1:0] nb;
    if (cyc < MAXC) begin
      rst_h[cyc] = wb_rst_i;
      ext_h[cyc] = ext_reset_n;
      pin_h[cyc] = btn_n_i;

      check("btn_o",              cyc, btn_o,              exp_btn);
      check("btn_press_o",        cyc, btn_press_o,        exp_press);
      check("btn_release_o",      cyc, btn_release_o,      exp_rel);
      check("design_reset_o",     cyc, design_reset_o,     exp_drst);
      check("debug_gpio_ready_o", cyc, debug_gpio_ready_o, exp_dbg);

      clr   = sync_cleared(cyc);
      ext_s = clr ? 1'b0 : ext_h[cyc-SYNC];
      cause_h[cyc] = wb_rst_i | !ext_s | !gpio_ready;

      // Design reset is low only after RH consecutive cause-free cycles.
      nd = 1'b0;
      for (int k = 0; k < RH; k++) nd |= cause_at(cyc - k);

      nb = exp_btn;
      for (int ch = 0; ch < NCH; ch++) begin
        s = clr ? 1'b0 : !pin_h[cyc-SYNC][ch];
        if (wb_rst_i) begin
          nb[ch] = 1'b0;
          disagree[ch] = 0;
        end else if (s != exp_btn[ch]) begin
          disagree[ch]++;
          if (disagree[ch] == DEB) begin
            nb[ch] = s;
            disagree[ch] = 0;
          end
        end else begin
          disagree[ch] = 0;
        end
      end

      exp_press = EDGE ? (nb & ~exp_btn & {NCH{!nd}}) : '0;
      exp_rel   = EDGE ? (~nb & exp_btn & {NCH{!nd}}) : '0;
      exp_btn   = nb;
      exp_drst  = nd;
      exp_dbg   = wb_rst_i ? 1'b0 : gpio_ready;
      cyc++;
    end
  end

  int scyc = -1;

  task automatic tick();
    @(posedge clk);
    #1;
    scyc++;
  endtask

  task automatic wait_until(input int c);
    while (scyc < c) tick();
  endtask

  int r0, p0, q0, b0, g0, m0;

  initial begin
    wb_rst_i    = 1'b1;
    ext_reset_n = 1'b1;
    gpio_ready  = 1'b1;
    btn_n_i     = '1;

    // Reset release: cycle r0 is the first cycle with wb_rst_i low.
    repeat (3) tick();
    tick();
    r0 = scyc;
    wb_rst_i = 1'b0;
    check("rst_btn_o",  scyc, btn_o, 0);
    check("rst_press",  scyc, btn_press_o, 0);
    check("rst_release", scyc, btn_release_o, 0);
    check("rst_design_reset", scyc, design_reset_o, 1);
    check("rst_debug",  scyc, debug_gpio_ready_o, 0);
    wait_until(r0 + 1);
    check("debug_follows_ready", scyc, debug_gpio_ready_o, 1);
    wait_until(r0 + 5);
    check("design_reset_still_high", scyc, design_reset_o, 1);
    wait_until(r0 + 6);
    check("design_reset_release", scyc, design_reset_o, 0);

    // Clean press and release on channel 1.
    p0 = r0 + 10;
    wait_until(p0);
    btn_n_i[1] = 1'b0;
    wait_until(p0 + 9);
    check("press_not_yet", scyc, btn_o, 0);
    wait_until(p0 + 10);
    check("press_level", scyc, btn_o, 4'b0010);
    check("press_pulse", scyc, btn_press_o, EDGE ? 4'b0010 : 4'b0000);
    wait_until(p0 + 11);
    check("press_pulse_one_cycle", scyc, btn_press_o, 0);
    q0 = p0 + 20;
    wait_until(q0);
    btn_n_i[1] = 1'b1;
    wait_until(q0 + 9);
    check("release_not_yet", scyc, btn_o, 4'b0010);
    wait_until(q0 + 10);
    check("release_level", scyc, btn_o, 0);
    check("release_pulse", scyc, btn_release_o, EDGE ? 4'b0010 : 4'b0000);
    wait_until(q0 + 11);
    check("release_pulse_one_cycle", scyc, btn_release_o, 0);

    // Bounce on channel 2: 5 low, 1 high, 5 low.
    b0 = q0 + 15;
    wait_until(b0);      btn_n_i[2] = 1'b0;
    wait_until(b0 + 5);  btn_n_i[2] = 1'b1;
    wait_until(b0 + 6);  btn_n_i[2] = 1'b0;
    wait_until(b0 + 11); btn_n_i[2] = 1'b1;
    wait_until(b0 + 25);
    check("bounce_rejected", scyc, btn_o, 0);

    // gpio_ready drop while channel 0 is mid-debounce.
    g0 = b0 + 30;
    wait_until(g0);
    btn_n_i[0] = 1'b0;
    wait_until(g0 + 6);
    check("drop_before", scyc, design_reset_o, 0);
    gpio_ready = 1'b0;
    wait_until(g0 + 7);
    check("drop_asserts", scyc, design_reset_o, 1);
    wait_until(g0 + 8);
    gpio_ready = 1'b1;
    wait_until(g0 + 10);
    check("drop_level_on_time", scyc, btn_o, 4'b0001);
    check("drop_press_gated", scyc, btn_press_o, 0);
    wait_until(g0 + 11);
    check("drop_hold", scyc, design_reset_o, 1);
    wait_until(g0 + 12);
    check("drop_release", scyc, design_reset_o, 0);
    wait_until(g0 + 15);
    btn_n_i[0] = 1'b1;

    // Simultaneous press on every channel.
    m0 = g0 + 40;
    wait_until(m0);
    btn_n_i = '0;
    wait_until(m0 + 10);
    check("multi_level", scyc, btn_o, 4'b1111);
    check("multi_pulse", scyc, btn_press_o, EDGE ? 4'b1111 : 4'b0000);
    wait_until(m0 + 15);
    btn_n_i = '1;
    wait_until(m0 + 40);

    // Random pins and reset causes, checked by the model every cycle.
    for (int i = 0; i < 800; i++) begin
      tick();
      for (int ch = 0; ch < NCH; ch++)
        if ($urandom_range(0, 6) == 0) btn_n_i[ch] = ~btn_n_i[ch];
      if (ext_reset_n) begin
        if ($urandom_range(0, 59) == 0) ext_reset_n = 1'b0;
      end else if ($urandom_range(0, 2) == 0) ext_reset_n = 1'b1;
      if (gpio_ready) begin
        if ($urandom_range(0, 49) == 0) gpio_ready = 1'b0;
      end else if ($urandom_range(0, 2) == 0) gpio_ready = 1'b1;
      wb_rst_i = ($urandom_range(0, 199) == 0);
    end
    wb_rst_i    = 1'b0;
    ext_reset_n = 1'b1;
    gpio_ready  = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/io_input_conditioner.md
# io_input_conditioner

Parametrised front-end for the game core's player inputs and reset/readiness pins. Sits between the raw Caravel GPIO/LA signals and the game core. Generalises the current fixed set of four active-low buttons to `NUM_CH` channels with:
- synchronisation,
- per-channel debouncing,
- press/release edge pulses,
- a reset sequencer that merges `wb_rst_i`, `ext_reset_n` and `gpio_ready` into one clean, held design reset.

## Interface
Parameters:
- `NUM_CH`, 4, number of button channels (pause, new game, down, up).
- `SYNC_STAGES`, 2, synchroniser depth for async pins; minimum 2.
- `DEBOUNCE_CYCLES`, 250000, consecutive stable cycles needed to accept a change; minimum 2.
- `RESET_HOLD`, 16, cause-free cycles before the design reset is released; minimum 1.

Ports:
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_i`  in  1  reset; synchronous, active-high.
- `ext_reset_n`  in  1  async external reset pin, active-low.
- `gpio_ready`  in  1  from `la_data_in[0]`; already synchronous to `wb_clk_i`.
- `btn_n_i`  in  NUM_CH  raw async button pins, active-low.
- `btn_o`  out  NUM_CH  debounced level, active-high (1 = pressed).
- `btn_press_o`  out  NUM_CH  one-cycle pulse when `btn_o` bit rises.
- `btn_release_o`  out  NUM_CH  one-cycle pulse when `btn_o` bit falls.
- `design_reset_o`  out  1  reset to the game core, active-high.
- `debug_gpio_ready_o`  out  1  registered copy of `gpio_ready`.

## Operation
- **Reset values** (`wb_rst_i`=1): all outputs 0 except `design_reset_o`=1.
  - Button synchroniser flops reset to 0 (released).
  - `ext_reset_n` synchroniser flops reset to 0 (reset asserted).
  - All counters reset to 0.
- **Synchronisers**: `SYNC_STAGES` flops per button and for `ext_reset_n`. Buttons are inverted before the first stage.
- **Debounce**, per channel, with `s` = synchronised level:
  - `s == btn_o`: counter cleared.
  - Otherwise the counter increments.
  - If the counter equals `DEBOUNCE_CYCLES-1` while `s != btn_o`: `btn_o <= s` and the counter clears.
  - Any single agreeing cycle restarts the count.
  - Counter width is `$clog2(DEBOUNCE_CYCLES)`; the counter never wraps.
- **Edge pulses**: `btn_press_o` and `btn_release_o` are registered together with the `btn_o` update.
  - They are high exactly in the first cycle of the new `btn_o` level.
  - They are forced 0 while `design_reset_o`=1. `btn_o` still tracks during reset.
- **Reset sequencer**, 2 states: HOLD (`design_reset_o`=1) and RUN (`design_reset_o`=0).
  - cause = `wb_rst_i` | !sync(`ext_reset_n`) | !`gpio_ready`.
  - Any state with cause → HOLD, hold counter cleared.
  - HOLD with no cause → counter increments. At `RESET_HOLD-1` the next state is RUN.
  - RUN with no cause → stay in RUN.
  - A cause arriving mid-count restarts the count from 0.
  - `design_reset_o` is the registered state.
- `debug_gpio_ready_o` = `gpio_ready` delayed one cycle.

## Timing
- Button pin edge to `btn_o`/pulse: exactly `SYNC_STAGES + DEBOUNCE_CYCLES` cycles, given a stable pin.
- Cause removal to `design_reset_o` low: `RESET_HOLD` cycles after the first cause-free cycle.
- After `wb_rst_i` deasserts, with pins idle and `gpio_ready`=1: low at cycle `SYNC_STAGES + RESET_HOLD`. Cycle 0 is the first cycle with `wb_rst_i` low.
- Cause assertion to `design_reset_o` high: 1 cycle for `gpio_ready`/`wb_rst_i`; `SYNC_STAGES+1` cycles for `ext_reset_n`.
- Simultaneous press on several channels: pulses are independent and may coincide.

## Configuration
- `IO_COND_EDGE_EN` defined: edge-pulse registers are generated as described.
- Undefined: no edge logic is generated. `btn_press_o` and `btn_release_o` are tied to 0; all other behaviour is identical.

## Structure
- Package `io_cond_pkg`:
  - default parameter constants (`IO_COND_NUM_CH`, `IO_COND_DEBOUNCE_CYCLES`, `IO_COND_RESET_HOLD`, `IO_COND_SYNC_STAGES`);
  - reset-sequencer state enum `rst_state_t` (`RST_HOLD`, `RST_RUN`).
- Sub-module `io_debounce_chan`: one synchroniser plus debounce counter plus optional edge registers. It is instantiated `NUM_CH` times via generate. The reset sequencer stays in the top module.

## Test plan
All scenarios use `NUM_CH`=4, `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=8, `RESET_HOLD`=4.
- **Reset release**: `wb_rst_i` high for 3 cycles, then low; `ext_reset_n`=1, `gpio_ready`=1, buttons idle → all outputs 0 except `design_reset_o`; `design_reset_o` falls at cycle 6 after release.
- **Clean press**: after the design reset releases, hold `btn_n_i[1]`=0 for 20 cycles → `btn_o[1]` rises 10 cycles after the pin edge; `btn_press_o[1]` is high for exactly that one cycle; other channels stay 0.
- **Bounce rejection**: `btn_n_i[2]` low for 5 cycles, high for 1, low for 5, then high → `btn_o[2]` stays 0 and there are no pulses.
- **Release**: release the pressed `btn_n_i[1]` → `btn_o[1]` falls 10 cycles later with a one-cycle `btn_release_o[1]`.
- **gpio_ready drop mid-press**:
  - Drop `gpio_ready` for 2 cycles while `btn_n_i[0]` is mid-debounce → `design_reset_o` goes high the next cycle.
  - `btn_o[0]` still rises on schedule, but `btn_press_o[0]` stays 0.
  - `design_reset_o` falls 4 cycles after `gpio_ready` returns.
- **Macro off**: build without `IO_COND_EDGE_EN` and repeat the clean-press scenario → identical `btn_o` timing; `btn_press_o` and `btn_release_o` constantly 0.
